// File: rtl/tx_pkt_ring_ctrl.sv
// Store-and-forward packet ring controller: drives an external simple dual-port RAM
// as a packet FIFO with commit-on-last, abort/rewind and a 2-entry read-side skid buffer.
module tx_pkt_ring_ctrl #(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDRESS_WIDTH = 9,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic                     s_last,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     s_abort,
   output logic                     ram_enable_a,
   output logic                     ram_write_enable,
   output logic [ADDRESS_WIDTH-1:0] ram_write_address,
   output logic [DATA_WIDTH:0]      ram_write_data,
   output logic                     ram_enable_b,
   output logic [ADDRESS_WIDTH-1:0] ram_read_address,
   input  logic [DATA_WIDTH:0]      ram_read_data,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [CNT_WIDTH-1:0]     pkt_count,
   output logic [ADDRESS_WIDTH:0]   fill_level
);

   localparam int PTR_WIDTH = ADDRESS_WIDTH + 1;
   localparam logic [PTR_WIDTH-1:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] commit_ptr_q, commit_ptr_d;
   logic [PTR_WIDTH-1:0] rd_issue_ptr_q, rd_issue_ptr_d;
   logic [PTR_WIDTH-1:0] used_words;
   logic                 full;
   logic                 empty;
   logic                 accept;
   logic                 commit;

   logic                 inflight_q, inflight_d;
   logic [DATA_WIDTH:0]  ob_word_q [2];
   logic [DATA_WIDTH:0]  ob_word_d [2];
   logic                 ob_head_q, ob_head_d;
   logic [1:0]           ob_count_q, ob_count_d;
   logic                 ob_tail;
   logic [2:0]           slots_used;
   logic                 issue;
   logic                 push;
   logic                 pop;
   logic                 drain_last;

   logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

   assign used_words = wr_ptr_q - rd_issue_ptr_q;
   assign full       = (used_words == DEPTH);
   assign empty      = (rd_issue_ptr_q == commit_ptr_q);

   assign s_ready           = !full && !reset;
   assign accept            = s_valid && s_ready && !s_abort;
   assign commit            = accept && s_last;
   assign ram_enable_a      = accept;
   assign ram_write_enable  = accept;
   assign ram_write_address = wr_ptr_q[ADDRESS_WIDTH-1:0];
   assign ram_write_data    = {s_last, s_data};

   // Abort rewinds to the last commit point and swallows any beat offered alongside it.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      if (s_abort) begin
         wr_ptr_d = commit_ptr_q;
      end else if (accept) begin
         wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         if (s_last) begin
            commit_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         end
      end
   end

   assign m_valid    = (ob_count_q != 2'd0);
   assign pop        = m_valid && m_ready;
   assign push       = inflight_q;
   assign drain_last = pop && m_last;
   assign ob_tail    = ob_head_q ^ ob_count_q[0];
   assign m_data     = ob_word_q[ob_head_q][DATA_WIDTH-1:0];
   assign m_last     = ob_word_q[ob_head_q][DATA_WIDTH];

   // A slot being popped this cycle counts as free so reads keep one beat per cycle.
   assign slots_used = {1'b0, ob_count_q} + {2'b0, inflight_q};
   assign issue      = !reset && !empty && (slots_used < (3'd2 + {2'b0, pop}));

   assign ram_enable_b     = issue;
   assign ram_read_address = rd_issue_ptr_q[ADDRESS_WIDTH-1:0];

   always_comb begin
      rd_issue_ptr_d = rd_issue_ptr_q;
      inflight_d     = issue;
      if (issue) begin
         rd_issue_ptr_d = rd_issue_ptr_q + PTR_WIDTH'(1);
      end
   end

   always_comb begin
      ob_word_d[0] = ob_word_q[0];
      ob_word_d[1] = ob_word_q[1];
      if (push) begin
         ob_word_d[ob_tail] = ram_read_data;
      end
      ob_head_d  = ob_head_q ^ pop;
      ob_count_d = ob_count_q + {1'b0, push} - {1'b0, pop};
   end

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (commit && !drain_last) begin
         pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      end else if (drain_last && !commit) begin
         pkt_count_d = pkt_count_q - CNT_WIDTH'(1);
      end
   end

   assign pkt_count  = pkt_count_q;
   assign fill_level = used_words;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         commit_ptr_q   <= '0;
         rd_issue_ptr_q <= '0;
         inflight_q     <= 1'b0;
         ob_word_q[0]   <= '0;
         ob_word_q[1]   <= '0;
         ob_head_q      <= 1'b0;
         ob_count_q     <= 2'd0;
         pkt_count_q    <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         commit_ptr_q   <= commit_ptr_d;
         rd_issue_ptr_q <= rd_issue_ptr_d;
         inflight_q     <= inflight_d;
         ob_word_q[0]   <= ob_word_d[0];
         ob_word_q[1]   <= ob_word_d[1];
         ob_head_q      <= ob_head_d;
         ob_count_q     <= ob_count_d;
         pkt_count_q    <= pkt_count_d;
      end
   end

endmodule

// File: tb/tb_tx_pkt_ring_ctrl.sv
// Directed bench for tx_pkt_ring_ctrl at a 16-word ring, with a read-first RAM model
// and an output scoreboard holding the hand-listed beats each scenario must emit.
module tb_tx_pkt_ring_ctrl;

   localparam int DW  = 64;
   localparam int AW  = 4;
   localparam int CW  = 8;

   logic          clock;
   logic          reset;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          s_valid;
   logic          s_ready;
   logic          s_abort;
   logic          ram_enable_a;
   logic          ram_write_enable;
   logic [AW-1:0] ram_write_address;
   logic [DW:0]   ram_write_data;
   logic          ram_enable_b;
   logic [AW-1:0] ram_read_address;
   logic [DW:0]   ram_read_data;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] pkt_count;
   logic [AW:0]   fill_level;

   int checkCount = 0;
   int passCount  = 0;
   bit randomReady = 0;
   logic [DW:0] expQ [$];
   logic [DW:0] ramMem [0:(1<<AW)-1];

   tx_pkt_ring_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset),
      .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready), .s_abort(s_abort),
      .ram_enable_a(ram_enable_a), .ram_write_enable(ram_write_enable),
      .ram_write_address(ram_write_address), .ram_write_data(ram_write_data),
      .ram_enable_b(ram_enable_b), .ram_read_address(ram_read_address), .ram_read_data(ram_read_data),
      .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .pkt_count(pkt_count), .fill_level(fill_level)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // Read-first RAM: a same-address write in the read cycle returns the old word.
   initial ram_read_data = '0;
   always @(posedge clock) begin
      if (ram_enable_b) ram_read_data <= ramMem[ram_read_address];
      if (ram_enable_a && ram_write_enable) ramMem[ram_write_address] <= ram_write_data;
   end

   task automatic checkOutput(input string tag, input logic [DW:0] observed, input logic [DW:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      else
         passCount++;
   endtask

   // Scoreboard: every accepted output beat must match the head of the expected list.
   initial forever begin
      @(negedge clock);
      if (!reset && m_valid === 1'b1 && m_ready === 1'b1) begin
         if (expQ.size() == 0)
            checkOutput("spurious_beat", {1'b0, m_valid}, '0);
         else
            checkOutput("m_beat", {m_last, m_data}, expQ.pop_front());
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (randomReady) m_ready = 1'($urandom_range(0, 1));
   end

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Offers one beat and returns just after the edge that accepted it.
   task automatic applyStimulus(input logic [DW-1:0] d, input logic last, input bit expectOut);
      int waitCount = 0;
      s_data  = d;
      s_last  = last;
      s_valid = 1;
      @(negedge clock);
      while (s_ready !== 1'b1 && waitCount < 300) begin
         @(negedge clock);
         waitCount++;
      end
      if (s_ready !== 1'b1) checkOutput("s_ready_timeout", {1'b0, s_ready}, 1);
      if (expectOut) expQ.push_back({last, d});
      stepCycle();
      s_valid = 0;
      s_last  = 0;
   endtask

   task automatic waitDrain(input string tag);
      int waitCount = 0;
      while ((expQ.size() != 0 || m_valid === 1'b1) && waitCount < 600) begin
         stepCycle();
         waitCount++;
      end
      checkOutput({tag, "_drained"}, expQ.size(), 0);
   endtask

   initial begin
      reset = 1; s_data = '0; s_last = 0; s_valid = 0; s_abort = 0; m_ready = 0;
      repeat (3) stepCycle();
      checkOutput("rst_s_ready", {1'b0, s_ready}, 0);
      checkOutput("rst_m_valid", {1'b0, m_valid}, 0);
      checkOutput("rst_pkt_count", pkt_count, 0);
      checkOutput("rst_fill", fill_level, 0);
      checkOutput("rst_enable_b", {1'b0, ram_enable_b}, 0);
      reset = 0;
      #1;
      checkOutput("post_rst_s_ready", {1'b0, s_ready}, 1);

      $display("[TB] basic 4-beat packet");
      m_ready = 1;
      applyStimulus(64'h10, 0, 1);
      applyStimulus(64'h11, 0, 1);
      applyStimulus(64'h12, 0, 1);
      checkOutput("t1_fill3", fill_level, 3);
      checkOutput("t1_precommit_cnt", pkt_count, 0);
      applyStimulus(64'h13, 1, 1);
      checkOutput("t1_commit_cnt", pkt_count, 1);
      checkOutput("t1_p0_m_valid", {1'b0, m_valid}, 0);
      checkOutput("t1_p0_enable_b", {1'b0, ram_enable_b}, 1);
      stepCycle();
      checkOutput("t1_p1_m_valid", {1'b0, m_valid}, 0);
      for (int k = 0; k < 4; k++) begin
         stepCycle();
         checkOutput("t1_stream_valid", {1'b0, m_valid}, 1);
         checkOutput("t1_stream_data", {m_last, m_data}, {(k == 3), 64'h10 + 64'(k)});
      end
      stepCycle();
      checkOutput("t1_end_m_valid", {1'b0, m_valid}, 0);
      checkOutput("t1_end_cnt", pkt_count, 0);

      $display("[TB] abort partial packet");
      applyStimulus(64'h20, 0, 0);
      applyStimulus(64'h21, 0, 0);
      applyStimulus(64'h22, 0, 0);
      checkOutput("t2_fill3", fill_level, 3);
      s_abort = 1; s_valid = 1; s_last = 1; s_data = 64'hDEAD;
      #1;
      checkOutput("t2_abort_no_write", {1'b0, ram_write_enable}, 0);
      stepCycle();
      s_abort = 0; s_valid = 0; s_last = 0;
      checkOutput("t2_abort_fill0", fill_level, 0);
      checkOutput("t2_abort_cnt0", pkt_count, 0);
      applyStimulus(64'hA0, 0, 1);
      applyStimulus(64'hA1, 1, 1);
      checkOutput("t2_commit_cnt", pkt_count, 1);
      s_abort = 1;
      stepCycle();
      s_abort = 0;
      checkOutput("t2_noop_abort_cnt", pkt_count, 1);
      waitDrain("t2");
      checkOutput("t2_end_cnt", pkt_count, 0);

      $display("[TB] fill to full");
      m_ready = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(64'h100 + 64'(i), (i == 15), 1);
         if (i == 7) checkOutput("t3_fill8", fill_level, 8);
      end
      checkOutput("t3_full_s_ready", {1'b0, s_ready}, 0);
      checkOutput("t3_full_fill", fill_level, 16);
      checkOutput("t3_full_cnt", pkt_count, 1);
      s_valid = 1; s_data = 64'h999; s_last = 0;
      #1;
      checkOutput("t3_full_no_write", {1'b0, ram_write_enable}, 0);
      stepCycle();
      s_valid = 0;
      checkOutput("t3_after_issue_fill", fill_level, 15);
      checkOutput("t3_after_issue_ready", {1'b0, s_ready}, 1);
      m_ready = 1;
      waitDrain("t3");
      checkOutput("t3_end_fill", fill_level, 0);

      $display("[TB] wrap with random m_ready");
      randomReady = 1;
      for (int p = 0; p < 20; p++) begin
         for (int b = 0; b < 10; b++)
            applyStimulus(64'h4000 + 64'(p * 16 + b), (b == 9), 1);
         checkOutput("t4_pkt_bound", {64'h0, (pkt_count <= 8'(p + 1))}, 1);
      end
      @(negedge clock);
      randomReady = 0;
      stepCycle();
      m_ready = 1;
      waitDrain("t4");
      checkOutput("t4_end_cnt", pkt_count, 0);
      checkOutput("t4_end_fill", fill_level, 0);

      $display("[TB] commit and drain-last together");
      m_ready = 0;
      applyStimulus(64'h50, 0, 1);
      applyStimulus(64'h51, 1, 1);
      repeat (4) stepCycle();
      m_ready = 1;
      stepCycle();
      m_ready = 0;
      checkOutput("t5_head_last", {m_last, m_data}, {1'b1, 64'h51});
      applyStimulus(64'h60, 0, 1);
      checkOutput("t5_before_cnt", pkt_count, 1);
      s_data = 64'h61; s_last = 1; s_valid = 1; m_ready = 1;
      expQ.push_back({1'b1, 64'h61});
      #1;
      checkOutput("t5_both_write", {1'b0, ram_write_enable}, 1);
      stepCycle();
      s_valid = 0; s_last = 0;
      checkOutput("t5_same_cycle_cnt", pkt_count, 1);
      waitDrain("t5");
      checkOutput("t5_end_cnt", pkt_count, 0);

      $display("[TB] reset mid-packet and mid-drain");
      m_ready = 0;
      for (int i = 0; i < 4; i++) applyStimulus(64'h70 + 64'(i), (i == 3), 0);
      repeat (4) stepCycle();
      checkOutput("t6_pre_m_valid", {1'b0, m_valid}, 1);
      applyStimulus(64'h80, 0, 0);
      applyStimulus(64'h81, 0, 0);
      reset = 1; s_valid = 1; s_data = 64'h82;
      stepCycle();
      checkOutput("t6_rst_m_valid", {1'b0, m_valid}, 0);
      checkOutput("t6_rst_cnt", pkt_count, 0);
      checkOutput("t6_rst_fill", fill_level, 0);
      checkOutput("t6_rst_s_ready", {1'b0, s_ready}, 0);
      s_valid = 0; reset = 0;
      m_ready = 1;
      applyStimulus(64'h90, 0, 1);
      applyStimulus(64'h91, 0, 1);
      applyStimulus(64'h92, 1, 1);
      waitDrain("t6");
      checkOutput("t6_end_cnt", pkt_count, 0);
      checkOutput("t6_end_fill", fill_level, 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
